pe_result_drain: RTL and testbench

//  Return-path partner of the PE array: captures one result frame (array_output lanes

---
 rtl/pe_result_drain.sv | 146 ++++++++++++++
 tb/tb_pe_result_drain.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_result_drain.sv
// pe_result_drain: captures one PE-array result frame (LANES lanes plus an
// optional scalar) and streams it out one DW-bit word at a time over a
// valid/ready interface. It holds up to two frames. The active frame is the
// one draining, and the pending frame waits behind it, so the array can deliver
// the next frame before the current one has finished draining.
module pe_result_drain #(
  parameter int DW             = 32,
  parameter int LANES          = 16,
  parameter int IDX_W          = 5,
  parameter int INCLUDE_SCALAR = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cap_valid,
  output logic                cap_ready,
  input  logic [LANES*DW-1:0] array_flat,
  input  logic [DW-1:0]       scalar_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out_data,
  output logic [IDX_W-1:0]    out_idx,
  output logic                out_last,
  output logic                busy,
  output logic [15:0]         frame_cnt
);

  localparam int              NW       = LANES + ((INCLUDE_SCALAR != 0) ? 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);

  typedef enum logic {S_IDLE, S_SEND} state_e;

  state_e              state_q, state_d;
  logic [NW*DW-1:0]    in_frame, act_q, pend_q;
  logic                pend_full_q, pend_full_d;
  logic                cap_ready_q;
  logic [IDX_W-1:0]    idx_q, idx_d, idx_inc;
  logic [DW-1:0]       data_q, data_d;
  logic                last_q, last_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                capture, word_acc, last_acc;
  logic                cap_to_act, cap_to_pend, act_from_pend, act_load;

  // When the scalar is enabled it is the highest-numbered word of the frame.
  generate
    if (INCLUDE_SCALAR != 0) begin : g_scalar
      assign in_frame = {scalar_in, array_flat};
    end else begin : g_lanes
      assign in_frame = array_flat;
    end
  endgenerate

  // The active slot is full exactly when the FSM is in SEND. A capture goes to
  // the active slot if that slot is free, or if it frees up this cycle and no
  // frame is pending. Otherwise the capture goes to the pending slot.
  assign capture       = cap_valid & cap_ready_q;
  assign word_acc      = (state_q == S_SEND) & out_ready;
  assign last_acc      = word_acc & (idx_q == LAST_IDX);
  assign cap_to_act    = capture & ((state_q == S_IDLE) | (last_acc & ~pend_full_q));
  assign cap_to_pend   = capture & ~cap_to_act;
  assign act_from_pend = last_acc & pend_full_q;
  assign act_load      = cap_to_act | act_from_pend;
  assign idx_inc       = idx_q + 1'b1;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked blocks use non-blocking (<=) so every register samples
    // pre-edge values, independent of statement or block ordering.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: leave SEND only when the last word goes out and no frame follows.
  always_comb begin
    // NOTE: a default assignment on entry keeps every path assigned, so no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE: if (cap_to_act)             state_d = S_SEND;
      S_SEND: if (last_acc && !act_load)  state_d = S_IDLE;
      default:                            state_d = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    out_valid = (state_q == S_SEND);
    busy      = (state_q == S_SEND) | pend_full_q;
  end

  // Word selection: start a newly loaded frame at index 0, or advance on accept.
  always_comb begin
    idx_d       = idx_q;
    data_d      = data_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    pend_full_d = pend_full_q;
    if (act_load) begin
      idx_d  = '0;
      last_d = (NW == 1);
      data_d = act_from_pend ? pend_q[DW-1:0] : in_frame[DW-1:0];
    end else if (last_acc) begin
      idx_d  = '0;
      last_d = 1'b0;
    end else if (word_acc) begin
      idx_d  = idx_inc;
      last_d = (idx_inc == LAST_IDX);
      data_d = act_q[idx_inc*DW +: DW];
    end
    if (last_acc)           cnt_d       = cnt_q + 16'd1;
    if (act_from_pend)      pend_full_d = 1'b0;
    else if (cap_to_pend)   pend_full_d = 1'b1;
  end

  // Output and bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
      cnt_q       <= '0;
      pend_full_q <= 1'b0;
      cap_ready_q <= 1'b1;
    end else begin
      idx_q       <= idx_d;
      data_q      <= data_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      pend_full_q <= pend_full_d;
      cap_ready_q <= ~pend_full_d;
    end
  end

  // Frame slot storage. The slots are written only when a frame is loaded.
  always_ff @(posedge clk) begin
    // NOTE: the slots are not reset. The full flags say whether a slot holds
    // valid data, so clearing the slots would only add reset fan-out.
    if (act_load)    act_q  <= act_from_pend ? pend_q : in_frame;
    if (cap_to_pend) pend_q <= in_frame;
  end

  assign cap_ready = cap_ready_q;
  assign out_data  = data_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_pe_result_drain.sv
// Bench for pe_result_drain: a table of per-cycle vectors, hand-written
// multi-cycle corner cases, and randomized traffic checked against a
// queue-of-frames reference model.
module tb_pe_result_drain;

  localparam int DW    = 32;
  localparam int LANES = 16;
  localparam int IDX_W = 5;
  localparam int NW    = LANES + 1;

  typedef logic [NW*DW-1:0] frame_t;

  typedef struct {
    logic        rst;
    logic        cv;
    logic        rdy;
    logic [31:0] base;
    logic [31:0] sc;
    logic        e_valid;
    logic [4:0]  e_idx;
    logic        e_last;
    logic [31:0] e_data;
    logic        e_capr;
    logic        e_busy;
    logic [15:0] e_cnt;
  } vec_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                cap_valid = 1'b0;
  logic                out_ready = 1'b0;
  logic                cap_ready, out_valid, out_last, busy;
  logic [DW-1:0]       out_data;
  logic [IDX_W-1:0]    out_idx;
  logic [15:0]         frame_cnt;
  logic [LANES*DW-1:0] array_flat;
  logic [DW-1:0]       scalar_in;
  frame_t              cur_frame = '0;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the frames held, oldest first, and the position within the head frame.
  frame_t      fq[$];
  int          pos  = 0;
  logic [15:0] mcnt = '0;

  vec_t vecs[$];

  assign array_flat = cur_frame[LANES*DW-1:0];
  assign scalar_in  = cur_frame[NW*DW-1 -: DW];

  pe_result_drain #(.DW(DW), .LANES(LANES), .IDX_W(IDX_W), .INCLUDE_SCALAR(1)) dut (
    .clk(clk), .rst(rst),
    .cap_valid(cap_valid), .cap_ready(cap_ready),
    .array_flat(array_flat), .scalar_in(scalar_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic frame_t mk_frame(input logic [31:0] base, input logic [31:0] sc);
    frame_t f;
    for (int i = 0; i < LANES; i++) f[i*DW +: DW] = base + 32'(i);
    f[LANES*DW +: DW] = sc;
    return f;
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    for (int i = 0; i < NW; i++) f[i*DW +: DW] = $urandom;
    return f;
  endfunction

  function automatic logic [63:0] pack(input logic v, input logic capr, input logic bsy,
                                       input logic [15:0] cnt, input logic last,
                                       input logic [4:0] idx, input logic [31:0] data);
    return {7'b0, v, capr, bsy, cnt, (v ? {last, idx, data} : 38'b0)};
  endfunction

  function automatic logic [63:0] dut_obs(input logic ev);
    return {7'b0, out_valid, cap_ready, busy, frame_cnt,
            (ev ? {out_last, out_idx, out_data} : 38'b0)};
  endfunction

  function automatic logic [63:0] m_obs();
    if (fq.size() > 0)
      return pack(1'b1, fq.size() < 2, 1'b1, mcnt, pos == NW - 1, 5'(pos),
                  fq[0][pos*DW +: DW]);
    return pack(1'b0, 1'b1, 1'b0, mcnt, 1'b0, 5'd0, 32'd0);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One clock of the abstract model. A word leaves the head frame when the
  // frame is presented and accepted. A capture is taken when fewer than two
  // frames are held.
  task automatic model_step(input logic cv, input logic rdy, input frame_t f);
    logic cap;
    cap = cv && (fq.size() < 2);
    if (fq.size() > 0 && rdy) begin
      if (pos == NW - 1) begin
        void'(fq.pop_front());
        pos  = 0;
        mcnt = mcnt + 16'd1;
      end else begin
        pos++;
      end
    end
    if (cap) fq.push_back(f);
  endtask

  task automatic model_reset();
    fq.delete();
    pos  = 0;
    mcnt = '0;
  endtask

  // Called at a negedge. Applies one cycle of stimulus and compares all outputs with the model.
  task automatic tick(input logic cv, input logic rdy, input string nm);
    cap_valid = cv;
    out_ready = rdy;
    model_step(cv, rdy, cur_frame);
    @(posedge clk);
    @(negedge clk);
    check(nm, dut_obs(fq.size() > 0), m_obs());
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    cap_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic add_row(input logic r, input logic cv, input logic rdy,
                         input logic [31:0] base, input logic [31:0] sc,
                         input logic ev, input int eidx, input logic el,
                         input logic [31:0] ed, input logic ecr, input logic eb,
                         input logic [15:0] ec);
    vec_t v;
    v.rst = r; v.cv = cv; v.rdy = rdy; v.base = base; v.sc = sc;
    v.e_valid = ev; v.e_idx = 5'(eidx); v.e_last = el; v.e_data = ed;
    v.e_capr = ecr; v.e_busy = eb; v.e_cnt = ec;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] b, s;
    logic        was_last;
    frame_t      fb;

    // Vector table. Each row is one cycle of inputs and the outputs expected after that edge.
    add_row(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'd0);
    b = 32'h1000_0000; s = 32'hDEAD_BEEF;
    add_row(0, 1, 1, b, s, 1, 0, 0, b, 1, 1, 16'd0);
    for (int j = 1; j <= 16; j++)
      add_row(0, 0, 1, b, s, 1, j, j == 16, (j < 16) ? b + 32'(j) : s, 1, 1, 16'd0);
    add_row(0, 0, 1, b, s, 0, 0, 0, 0, 1, 0, 16'd1);
    b = 32'h2000_0000; s = 32'hCAFE_F00D;
    add_row(0, 1, 0, b, s, 1, 0, 0, b, 1, 1, 16'd1);
    for (int j = 1; j <= 33; j++) begin
      int k;
      k = (j + 1) / 2;
      if (j < 33)
        add_row(0, 0, (j % 2) == 1, b, s, 1, k, k == 16, (k < 16) ? b + 32'(k) : s, 1, 1, 16'd1);
      else
        add_row(0, 0, 1, b, s, 0, 0, 0, 0, 1, 0, 16'd2);
    end

    repeat (2) @(negedge clk);
    foreach (vecs[i]) begin
      rst       = vecs[i].rst;
      cap_valid = vecs[i].cv;
      out_ready = vecs[i].rdy;
      cur_frame = mk_frame(vecs[i].base, vecs[i].sc);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d", i), dut_obs(vecs[i].e_valid),
            pack(vecs[i].e_valid, vecs[i].e_capr, vecs[i].e_busy, vecs[i].e_cnt,
                 vecs[i].e_last, vecs[i].e_idx, vecs[i].e_data));
    end

    // Ping-pong: A, then B three cycles later, then C offered while the pending slot is full.
    do_reset();
    cur_frame = mk_frame(32'h3000_0000, 32'hAAAA_0001);
    tick(1, 1, "pp_capA");
    cur_frame = mk_frame(32'h4000_0000, 32'hBBBB_0002);
    tick(0, 1, "pp_gap1");
    tick(0, 1, "pp_gap2");
    tick(1, 1, "pp_capB");
    check("pp_cap_ready_low", 64'(cap_ready), 64'd0);
    cur_frame = mk_frame(32'h7000_0000, 32'hCCCC_0003);
    for (int i = 0; i < 40 && fq.size() >= 2; i++) begin
      was_last = (pos == NW - 1);
      tick(1, 1, "pp_window");
      if (was_last)
        check("pp_no_bubble", 64'({out_valid, out_idx, out_data}),
              64'({1'b1, 5'd0, 32'h4000_0000}));
    end
    check("pp_cap_ready_high", 64'(cap_ready), 64'd1);
    for (int i = 0; i < 17; i++) tick(0, 1, "pp_drainB");
    check("pp_C_ignored", 64'({out_valid, busy, frame_cnt}), 64'({1'b0, 1'b0, 16'd2}));

    // Coincident: B is captured in the same cycle that A's last word is accepted.
    do_reset();
    cur_frame = mk_frame(32'h5000_0000, 32'h5555_AAAA);
    tick(1, 1, "co_capA");
    cur_frame = mk_frame(32'h5100_0000, 32'h5151_BBBB);
    for (int i = 0; i < 16; i++) tick(0, 1, "co_drainA");
    check("co_A_last", 64'({out_valid, out_last, out_idx}), 64'({1'b1, 1'b1, 5'd16}));
    tick(1, 1, "co_capB");
    check("co_B_first", 64'({out_valid, out_idx, out_data, frame_cnt}),
          64'({1'b1, 5'd0, 32'h5100_0000, 16'd1}));
    for (int i = 0; i < 17; i++) tick(0, 1, "co_drainB");
    check("co_cnt2", 64'({out_valid, frame_cnt}), 64'({1'b0, 16'd2}));

    // Mid-frame reset: reset arrives between clock edges while word 5 of a frame is presented.
    cur_frame = mk_frame(32'h6000_0000, 32'h6666_6666);
    tick(1, 1, "mr_capA");
    for (int i = 0; i < 5; i++) tick(0, 1, "mr_adv");
    check("mr_idx5", 64'({out_valid, out_idx}), 64'({1'b1, 5'd5}));
    #2 rst = 1'b1;
    #1 check("mr_async_reset", 64'({out_valid, out_data, out_idx, out_last, cap_ready, busy, frame_cnt}),
             64'({1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0, 16'd0}));
    model_reset();
    cap_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    fb = mk_frame(32'h6100_0000, 32'h6161_6161);
    cur_frame = fb;
    tick(1, 1, "mr_new_cap");
    check("mr_new_first", 64'({out_valid, out_idx, out_data, frame_cnt}),
          64'({1'b1, 5'd0, 32'h6100_0000, 16'd0}));
    for (int i = 0; i < 17; i++) tick(0, 1, "mr_drain");

    // Randomized traffic checked against the model, with occasional resets.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      cur_frame = rand_frame();
      tick($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
